// File: rtl/speed_ctrl_pkg.sv
// Shared definitions for the speed level controller: state encoding and
// saturating arithmetic used by the brake path.
package speed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ESTOP = 2'b10
  } state_e;

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/speed_dwell_timer.sv
// Counts consecutive accelerate cycles; done pulses on the cycle the count
// sits at ACC_DWELL-1 so the step up lands on the following edge.
module speed_dwell_timer #(
  parameter int ACC_DWELL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic hold,
  output logic done
);

  localparam int CW = $clog2(ACC_DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = inc && !clr && !hold && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || hold || !inc) begin
      cnt_d = '0;
    end else if (done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/speed_level_ctrl.sv
// Speed level FSM: estop > brake > accelerate > hold, with a latched
// emergency-stop state that exits only once both estop and accelerate drop.
module speed_level_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int LEVELS    = 4,
  parameter int ACC_DWELL = 3,
  parameter int BRK_STEP  = 1,
  localparam int LW       = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          brake,
  input  logic          accelerate,
  input  logic          estop,
  output logic [LW-1:0] speed,
  output logic [1:0]    state,
  output logic          at_max,
  output logic          step_up,
  output logic          step_down
);

  if (LEVELS < 2) begin : g_bad_levels
    $fatal(1, "speed_level_ctrl: LEVELS must be >= 2");
  end
  if (ACC_DWELL < 1) begin : g_bad_dwell
    $fatal(1, "speed_level_ctrl: ACC_DWELL must be >= 1");
  end
  if ((BRK_STEP < 1) || (BRK_STEP > LEVELS - 1)) begin : g_bad_brk
    $fatal(1, "speed_level_ctrl: BRK_STEP must be in 1..LEVELS-1");
  end

  localparam logic [LW-1:0] MAX_SPD = LW'(LEVELS - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] speed_q, speed_d;
  logic          at_max_q, up_q, dn_q;
  logic          up_d, dn_d;
  logic          dwell_clr, dwell_done;

  // Any non-accelerating cycle, and every cycle outside STOP/RUN, restarts the dwell.
  assign dwell_clr = estop || brake || !accelerate ||
                     !((state_q == ST_STOP) || (state_q == ST_RUN));

  speed_dwell_timer #(
    .ACC_DWELL(ACC_DWELL)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (dwell_clr),
    .inc  (accelerate),
    .hold (speed_q == MAX_SPD),
    .done (dwell_done)
  );

  always_comb begin
    speed_d = speed_q;
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    case (state_q)
      ST_ESTOP: begin
        speed_d = '0;
        if (!estop && !accelerate) state_d = ST_STOP;
      end
      ST_STOP, ST_RUN: begin
        if (estop) begin
          speed_d = '0;
          dn_d    = (speed_q != '0);
          state_d = ST_ESTOP;
        end else begin
          if (brake) begin
            speed_d = LW'(sat_sub(32'(speed_q), BRK_STEP));
            dn_d    = (speed_d != speed_q);
          end else if (dwell_done) begin
            speed_d = speed_q + LW'(1);
            up_d    = 1'b1;
          end
          state_d = (speed_d != '0) ? ST_RUN : ST_STOP;
        end
      end
      default: begin
        speed_d = '0;
        state_d = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_STOP;
      speed_q  <= '0;
      at_max_q <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      at_max_q <= (speed_d == MAX_SPD);
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

  assign speed     = speed_q;
  assign state     = state_q;
  assign at_max    = at_max_q;
  assign step_up   = up_q;
  assign step_down = dn_q;

endmodule
